// File: rtl/eth_tx_sched.sv
// eth_tx_sched: shares the single ARP transmitter between queued automatic
// replies and explicit host send requests. Round-robin arbitration, level
// req / pulse done handshake towards eth_send, with an ack timeout.
module eth_tx_sched #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                          i_rx_clk,
    input  logic                          rst_n,
    input  logic                          i_auto_en,
    input  logic [31:0]                   i_local_ip,
    input  logic [1:0]                    i_pkt_type,
    input  logic [47:0]                   i_SHA,
    input  logic [31:0]                   i_SPA,
    input  logic [31:0]                   i_TPA,
    input  logic                          i_host_req,
    input  logic [1:0]                    i_host_op,
    input  logic [47:0]                   i_host_tha,
    input  logic [31:0]                   i_host_tpa,
    output logic                          o_host_busy,
    output logic                          o_tx_req,
    output logic [1:0]                    o_tx_op,
    output logic [47:0]                   o_tx_tha,
    output logic [31:0]                   o_tx_tpa,
    input  logic                          i_tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [7:0]                    o_drop_cnt,
    output logic [7:0]                    o_tmo_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [79:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [79:0]     head;
    logic [1:0]      host_op;
    logic [47:0]     host_tha;
    logic [31:0]     host_tpa;
    logic            last_host;   // 1: host won the previous grant
    logic            cur_host;    // 1: the send in service belongs to the host
    logic [TW-1:0]   timer;

    logic push_req;
    logic auto_rdy;
    logic grant_auto;
    logic grant_host;
    logic fifo_full;
    logic accept;
    logic drop;
    logic tmo_hit;
    logic req_end;

    // Arbitration and queue bookkeeping decisions for this cycle.
    assign push_req   = (i_pkt_type == 2'b01) && i_auto_en && (i_TPA == i_local_ip);
    assign auto_rdy   = (o_fifo_level != '0);
    assign grant_host = (state == IDLE) && o_host_busy && (!auto_rdy || !last_host);
    assign grant_auto = (state == IDLE) && auto_rdy && (!o_host_busy || last_host);
    assign fifo_full  = (o_fifo_level == FULL_LVL);
    // A full queue still accepts when the head leaves in the same cycle.
    assign accept     = push_req && (!fifo_full || grant_auto);
    assign drop       = push_req && fifo_full && !grant_auto;
    assign tmo_hit    = (state == REQ) && !i_tx_done && (timer == TMO_LAST);
    assign req_end    = (state == REQ) && (i_tx_done || timer == TMO_LAST);
    assign head       = mem[rd_ptr];

    // Queue storage: {SHA, SPA} of each pending auto-reply.
    // NOTE: storage is deliberately not reset; the level counter alone says which entries are valid.
    always_ff @(posedge i_rx_clk) begin
        if (accept) mem[wr_ptr] <= {i_SHA, i_SPA};
    end

    // Queue pointers, fill level and saturating drop counter.
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_level <= '0;
            o_drop_cnt   <= '0;
        end else begin
            if (accept)     wr_ptr <= wr_ptr + AW'(1);
            if (grant_auto) rd_ptr <= rd_ptr + AW'(1);
            case ({accept, grant_auto})
                2'b10:   o_fifo_level <= o_fifo_level + LW'(1);
                2'b01:   o_fifo_level <= o_fifo_level - LW'(1);
                default: o_fifo_level <= o_fifo_level;
            endcase
            if (drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end

    // Host request latch; busy from acceptance until its send leaves REQ.
    always_ff @(posedge i_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_host_busy <= 1'b0;
            host_op     <= '0;
            host_tha    <= '0;
            host_tpa    <= '0;
        end else if (!o_host_busy) begin
            if (i_host_req) begin
                o_host_busy <= 1'b1;
                host_op     <= i_host_op;
                host_tha    <= i_host_tha;
                host_tpa    <= i_host_tpa;
            end
        end else if (req_end && cur_host) begin
            o_host_busy <= 1'b0;
        end
    end

    // Send sequencer: grant in IDLE, hold request in REQ, one idle cycle in GAP.
    always_ff @(posedge i_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            o_tx_req  <= 1'b0;
            o_tx_op   <= '0;
            o_tx_tha  <= '0;
            o_tx_tpa  <= '0;
            cur_host  <= 1'b0;
            last_host <= 1'b0;
            timer     <= '0;
            o_tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (grant_host) begin
                        o_tx_op   <= host_op;
                        o_tx_tha  <= host_tha;
                        o_tx_tpa  <= host_tpa;
                        cur_host  <= 1'b1;
                        last_host <= 1'b1;
                        o_tx_req  <= 1'b1;
                        state     <= REQ;
                    end else if (grant_auto) begin
                        o_tx_op   <= 2'b10;
                        o_tx_tha  <= head[79:32];
                        o_tx_tpa  <= head[31:0];
                        cur_host  <= 1'b0;
                        last_host <= 1'b0;
                        o_tx_req  <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (req_end) begin
                        o_tx_req <= 1'b0;
                        state    <= GAP;
                        if (tmo_hit && o_tmo_cnt != 8'hFF) o_tmo_cnt <= o_tmo_cnt + 8'd1;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    o_tx_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched: auto-reply path, filtering, queue overflow,
// round-robin with the host, ack timeout and asynchronous reset.
module tb_eth_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        auto_en;
    logic [31:0] local_ip;
    logic [1:0]  pkt_type;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
    logic        host_req;
    logic [1:0]  host_op;
    logic [47:0] host_tha;
    logic [31:0] host_tpa;
    logic        host_busy;
    logic        tx_req;
    logic [1:0]  tx_op;
    logic [47:0] tx_tha;
    logic [31:0] tx_tpa;
    logic        tx_done;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_cnt;
    logic [7:0]  tmo_cnt;

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] IP = 32'hC0A8_0105;

    always #5 clk = ~clk;

    eth_tx_sched #(.FIFO_DEPTH(4), .ACK_TIMEOUT(1024)) dut (
        .i_rx_clk     (clk),
        .rst_n        (rst_n),
        .i_auto_en    (auto_en),
        .i_local_ip   (local_ip),
        .i_pkt_type   (pkt_type),
        .i_SHA        (sha),
        .i_SPA        (spa),
        .i_TPA        (tpa),
        .i_host_req   (host_req),
        .i_host_op    (host_op),
        .i_host_tha   (host_tha),
        .i_host_tpa   (host_tpa),
        .o_host_busy  (host_busy),
        .o_tx_req     (tx_req),
        .o_tx_op      (tx_op),
        .o_tx_tha     (tx_tha),
        .o_tx_tpa     (tx_tpa),
        .i_tx_done    (tx_done),
        .o_fifo_level (fifo_level),
        .o_drop_cnt   (drop_cnt),
        .o_tmo_cnt    (tmo_cnt)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_arp(input logic [1:0] t, input logic [47:0] s_mac,
                            input logic [31:0] s_ip, input logic [31:0] t_ip);
        pkt_type = t;
        sha      = s_mac;
        spa      = s_ip;
        tpa      = t_ip;
        tick();
        pkt_type = 2'b00;
    endtask

    task automatic host_send(input logic [1:0] op, input logic [47:0] tha, input logic [31:0] tpa_v);
        host_req = 1'b1;
        host_op  = op;
        host_tha = tha;
        host_tpa = tpa_v;
        tick();
        host_req = 1'b0;
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b1;
        auto_en  = 1'b1;
        local_ip = IP;
        pkt_type = 2'b00;
        sha      = '0;
        spa      = '0;
        tpa      = '0;
        host_req = 1'b0;
        host_op  = '0;
        host_tha = '0;
        host_tpa = '0;
        tx_done  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req",   tx_req,     0);
        check("rst_busy",  host_busy,  0);
        check("rst_level", fifo_level, 0);
        check("rst_drop",  drop_cnt,   0);
        check("rst_tmo",   tmo_cnt,    0);
        check("rst_op",    tx_op,      0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single matching request, req rises two cycles after the pulse
        send_arp(2'b01, 48'h0011_2233_4455, 32'hC0A8_0164, IP);
        check("t1_level_push", fifo_level, 1);
        check("t1_req_early",  tx_req,     0);
        tick();
        check("t1_req",   tx_req,     1);
        check("t1_op",    tx_op,      2'b10);
        check("t1_tha",   tx_tha,     48'h0011_2233_4455);
        check("t1_tpa",   tx_tpa,     32'hC0A8_0164);
        check("t1_level", fifo_level, 0);
        tick();
        tick();
        check("t1_req_hold", tx_req, 1);
        check("t1_tha_hold", tx_tha, 48'h0011_2233_4455);
        done_pulse();
        check("t1_req_gap", tx_req, 0);
        tick();
        check("t1_req_idle", tx_req, 0);

        // 2: non-matching traffic is ignored
        send_arp(2'b01, 48'h0011_2233_4455, 32'hC0A8_0164, 32'hC0A8_0106);
        tick();
        check("t2_wrong_ip_level", fifo_level, 0);
        check("t2_wrong_ip_req",   tx_req,     0);
        auto_en = 1'b0;
        send_arp(2'b01, 48'h0011_2233_4455, 32'hC0A8_0164, IP);
        tick();
        check("t2_disabled_level", fifo_level, 0);
        check("t2_disabled_req",   tx_req,     0);
        auto_en = 1'b1;
        send_arp(2'b10, 48'h0011_2233_4455, 32'hC0A8_0164, IP);
        tick();
        check("t2_reply_level", fifo_level, 0);
        check("t2_reply_req",   tx_req,     0);
        send_arp(2'b11, 48'h0011_2233_4455, 32'hC0A8_0164, IP);
        tick();
        check("t2_other_level", fifo_level, 0);

        // 3: six back-to-back requests with the sender stalled
        for (int i = 0; i < 6; i++) begin
            pkt_type = 2'b01;
            sha      = 48'hA0A0_A0A0_A000 + 48'(i);
            spa      = 32'h0A00_0001 + 32'(i);
            tpa      = IP;
            tick();
        end
        pkt_type = 2'b00;
        check("t3_level_full", fifo_level, 4);
        check("t3_drop",       drop_cnt,   1);
        check("t3_req",        tx_req,     1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_tha_%0d", k), tx_tha, 48'hA0A0_A0A0_A000 + 48'(k));
            check($sformatf("t3_tpa_%0d", k), tx_tpa, 32'h0A00_0001 + 32'(k));
            done_pulse();
            check($sformatf("t3_gap_%0d", k), tx_req, 0);
            tick();
            check($sformatf("t3_idle_%0d", k), tx_req, 0);
            if (k < 4) begin
                tick();
                check($sformatf("t3_rise_%0d", k), tx_req, 1);
                check($sformatf("t3_level_%0d", k), fifo_level, 3'(3 - k));
            end
        end
        check("t3_level_end", fifo_level, 0);

        // 4: host vs auto round robin, last grant was auto
        host_req = 1'b1;
        host_op  = 2'b01;
        host_tha = 48'h0000_1111_2222;
        host_tpa = 32'hC0A8_0101;
        pkt_type = 2'b01;
        sha      = 48'hB1B1_B1B1_B1B1;
        spa      = 32'hC0A8_0111;
        tpa      = IP;
        tick();
        host_req = 1'b0;
        pkt_type = 2'b00;
        check("t4_busy",  host_busy,  1);
        check("t4_level", fifo_level, 1);
        tick();
        check("t4_host_req", tx_req, 1);
        check("t4_host_op",  tx_op,  2'b01);
        check("t4_host_tha", tx_tha, 48'h0000_1111_2222);
        check("t4_host_tpa", tx_tpa, 32'hC0A8_0101);
        host_send(2'b10, 48'h9999_9999_9999, 32'h0909_0909);
        check("t4_ignored_tha", tx_tha, 48'h0000_1111_2222);
        done_pulse();
        check("t4_busy_clear", host_busy, 0);
        tick();
        tick();
        check("t4_auto_req", tx_req, 1);
        check("t4_auto_op",  tx_op,  2'b10);
        check("t4_auto_tha", tx_tha, 48'hB1B1_B1B1_B1B1);
        // both ready again with last = auto: host goes first
        host_send(2'b10, 48'h0000_3333_4444, 32'hC0A8_0102);
        send_arp(2'b01, 48'hC1C1_C1C1_C1C1, 32'hC0A8_0121, IP);
        check("t4_busy2", host_busy, 1);
        done_pulse();
        tick();
        tick();
        check("t4_host2_tha", tx_tha, 48'h0000_3333_4444);
        check("t4_host2_op",  tx_op,  2'b10);
        // host re-requests during GAP; last = host, so the queued auto wins
        done_pulse();
        host_send(2'b01, 48'h0000_5555_6666, 32'hC0A8_0103);
        tick();
        check("t4_rr_auto_tha", tx_tha, 48'hC1C1_C1C1_C1C1);
        check("t4_rr_busy",     host_busy, 1);
        done_pulse();
        tick();
        tick();
        check("t4_host3_tha", tx_tha, 48'h0000_5555_6666);
        done_pulse();
        tick();

        // 5: ack timeout
        send_arp(2'b01, 48'hD0D0_D0D0_D0D0, 32'hC0A8_0130, IP);
        send_arp(2'b01, 48'hD1D1_D1D1_D1D1, 32'hC0A8_0131, IP);
        check("t5_req",   tx_req, 1);
        check("t5_tha0",  tx_tha, 48'hD0D0_D0D0_D0D0);
        repeat (1023) tick();
        check("t5_req_before_tmo", tx_req, 1);
        tick();
        check("t5_req_tmo", tx_req,  0);
        check("t5_tmo_cnt", tmo_cnt, 1);
        tick();
        check("t5_req_idle", tx_req, 0);
        tick();
        check("t5_next_req",   tx_req,     1);
        check("t5_next_tha",   tx_tha,     48'hD1D1_D1D1_D1D1);
        check("t5_next_level", fifo_level, 0);

        // 6: asynchronous reset mid-REQ with three queued
        send_arp(2'b01, 48'hE0E0_E0E0_E0E0, 32'hC0A8_0140, IP);
        send_arp(2'b01, 48'hE1E1_E1E1_E1E1, 32'hC0A8_0141, IP);
        send_arp(2'b01, 48'hE2E2_E2E2_E2E2, 32'hC0A8_0142, IP);
        check("t6_level_pre", fifo_level, 3);
        #2 rst_n = 1'b0;
        #1;
        check("t6_req",   tx_req,     0);
        check("t6_level", fifo_level, 0);
        check("t6_drop",  drop_cnt,   0);
        check("t6_tmo",   tmo_cnt,    0);
        check("t6_tha",   tx_tha,     0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t6_req_after", tx_req, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
